// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared constants, types and width helper for the CIC decimator comb section
// Contents:
//   DIFF_DELAY_MIN/MAX : legal range of the comb differential delay M
//   cic_dline_len_t    : type holding a comb delay-line length (1..DIFF_DELAY_MAX)
//   cic_width()        : register width needed for lossless CIC accumulation
package cic_pkg;

    localparam int DIFF_DELAY_MIN = 1;
    localparam int DIFF_DELAY_MAX = 2;

    typedef logic [$clog2(DIFF_DELAY_MAX+1)-1:0] cic_dline_len_t;

    // Bit growth of an N-stage CIC with decimation r and differential delay m
    // is n*log2(r*m); the integrators and combs must carry that many extra bits.
    function automatic int cic_width(input int in_bits, input int n, input int r, input int m);
        return in_bits + n * $clog2(r * m);
    endfunction

endpackage

// File: rtl/cic_comb.sv
// rtl/cic_comb.sv - one registered CIC comb stage, y = x - x[-DIFF_DELAY]
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   fire       : x is valid this clock; update y and shift the delay line
//   x          : stage input sample
//   y          : registered difference, modulo 2^WIDTH
//   y_valid    : y was updated on the last edge (one-clock pulse)
module cic_comb
    import cic_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DIFF_DELAY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fire,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    localparam cic_dline_len_t DLINE_LEN = cic_dline_len_t'(DIFF_DELAY);

    if (DIFF_DELAY < DIFF_DELAY_MIN || DIFF_DELAY > DIFF_DELAY_MAX) begin : g_bad_delay
        $error("cic_comb: DIFF_DELAY out of range");
    end

    logic [WIDTH-1:0] r_dline [int'(DLINE_LEN)];
    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
            for (int i = 0; i < int'(DLINE_LEN); i++) begin
                r_dline[i] <= '0;
            end
        end else begin
            r_y_valid <= fire;
            if (fire) begin
                // Subtraction wraps on purpose: CIC integrator overflow cancels here.
                r_y        <= x - r_dline[int'(DLINE_LEN)-1];
                r_dline[0] <= x;
                for (int i = 1; i < int'(DLINE_LEN); i++) begin
                    r_dline[i] <= r_dline[i-1];
                end
            end
        end
    end

    assign y       = r_y;
    assign y_valid = r_y_valid;

endmodule

// File: rtl/cic_decimator_comb.sv
// rtl/cic_decimator_comb.sv - CIC decimator back half: decimate, N comb stages, valid/ready output
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : input sample strobe shared with the integrators
//   data_in    : last integrator output (WIDTH, two's complement)
//   out_data   : filtered sample, top OUT_WIDTH bits of the final comb
//   out_valid  : out_data holds an unconsumed sample
//   out_ready  : consumer accepts out_data when out_valid & out_ready
//   overrun    : sticky, an unconsumed sample was overwritten
// Build option CIC_COMB_ROUND_EN: round-half-up with positive saturation instead of truncation.
module cic_decimator_comb
    import cic_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int N_STAGES   = 3,
    parameter int DECIM      = 8,
    parameter int DIFF_DELAY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [WIDTH-1:0]     data_in,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overrun
);

    localparam int                CNT_W    = $clog2(DECIM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    if (DECIM < 2 || N_STAGES < 1 || OUT_WIDTH > WIDTH) begin : g_bad_param
        $error("cic_decimator_comb: illegal DECIM, N_STAGES or OUT_WIDTH");
    end

    logic [CNT_W-1:0]               r_count;
    logic [WIDTH-1:0]               r_cap;
    logic                           r_cap_valid;
    logic [N_STAGES:0][WIDTH-1:0]   w_x;
    logic [N_STAGES:0]              w_v;
    logic [WIDTH-1:0]               w_final;
    logic [OUT_WIDTH-1:0]           w_result;
    logic [OUT_WIDTH-1:0]           r_out_data;
    logic                           r_out_valid;
    logic                           r_overrun;

    // Keep every DECIM-th sample: capture on the ena that completes the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_cap       <= '0;
            r_cap_valid <= 1'b0;
        end else begin
            r_cap_valid <= 1'b0;
            if (ena) begin
                if (r_count == CNT_LAST) begin
                    r_count     <= '0;
                    r_cap       <= data_in;
                    r_cap_valid <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign w_x[0] = r_cap;
    assign w_v[0] = r_cap_valid;

    for (genvar k = 0; k < N_STAGES; k++) begin : g_comb
        cic_comb #(
            .WIDTH      (WIDTH),
            .DIFF_DELAY (DIFF_DELAY)
        ) u_comb (
            .clk     (clk),
            .rst_n   (rst_n),
            .fire    (w_v[k]),
            .x       (w_x[k]),
            .y       (w_x[k+1]),
            .y_valid (w_v[k+1])
        );
    end

    assign w_final = w_x[N_STAGES];

`ifdef CIC_COMB_ROUND_EN
    localparam int               RSH  = (WIDTH > OUT_WIDTH) ? (WIDTH - OUT_WIDTH - 1) : 0;
    localparam logic [WIDTH-1:0] HALF = WIDTH'(1) << RSH;

    if (WIDTH <= OUT_WIDTH) begin : g_bad_round
        $error("cic_decimator_comb: rounding needs WIDTH > OUT_WIDTH");
    end

    logic [WIDTH-1:0] w_rsum;
    logic             w_rovf;

    // Only a non-negative value can cross into the sign bit when adding half an LSB.
    assign w_rsum   = w_final + HALF;
    assign w_rovf   = ~w_final[WIDTH-1] & w_rsum[WIDTH-1];
    assign w_result = w_rovf ? {1'b0, {(OUT_WIDTH-1){1'b1}}} : w_rsum[WIDTH-1 -: OUT_WIDTH];

    if (WIDTH > OUT_WIDTH) begin : g_drop_lsbs
        logic w_unused_lsbs;
        assign w_unused_lsbs = ^w_rsum[WIDTH-OUT_WIDTH-1:0];
    end
`else
    assign w_result = w_final[WIDTH-1 -: OUT_WIDTH];

    if (WIDTH > OUT_WIDTH) begin : g_drop_lsbs
        logic w_unused_lsbs;
        assign w_unused_lsbs = ^w_final[WIDTH-OUT_WIDTH-1:0];
    end
`endif

    // A load wins over a transfer; a load onto an unconsumed sample is an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_v[N_STAGES]) begin
                r_out_data  <= w_result;
                r_out_valid <= 1'b1;
                if (r_out_valid && !out_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_cic_decimator_comb.sv
// tb/tb_cic_decimator_comb.sv - self-checking bench for cic_decimator_comb
module tb_cic_decimator_comb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ena = 1'b0;
    logic        rdy_a = 1'b1;
    logic        rdy_o = 1'b1;
    logic [15:0] d_a = '0, d_c = '0, d_d = '0;
    logic [7:0]  d_b = '0;
    logic [15:0] o_a, o_d;
    logic [7:0]  o_b, o_c;
    logic        v_a, v_b, v_c, v_d, ov_a, ov_b, ov_c, ov_d;

    always #5 clk = ~clk;

    cic_decimator_comb #(.WIDTH(16), .OUT_WIDTH(16), .N_STAGES(1), .DECIM(4), .DIFF_DELAY(1)) u_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(d_a),
        .out_data(o_a), .out_valid(v_a), .out_ready(rdy_a), .overrun(ov_a));
    cic_decimator_comb #(.WIDTH(8), .OUT_WIDTH(8), .N_STAGES(1), .DECIM(4), .DIFF_DELAY(1)) u_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(d_b),
        .out_data(o_b), .out_valid(v_b), .out_ready(rdy_o), .overrun(ov_b));
    cic_decimator_comb #(.WIDTH(16), .OUT_WIDTH(8), .N_STAGES(1), .DECIM(4), .DIFF_DELAY(1)) u_c (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(d_c),
        .out_data(o_c), .out_valid(v_c), .out_ready(rdy_o), .overrun(ov_c));
    cic_decimator_comb #(.WIDTH(16), .OUT_WIDTH(16), .N_STAGES(3), .DECIM(2), .DIFF_DELAY(2)) u_d (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(d_d),
        .out_data(o_d), .out_valid(v_d), .out_ready(rdy_o), .overrun(ov_d));

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model, one slot per instance: a..d
    localparam int MW [4] = '{16, 8, 16, 16};
    localparam int MO [4] = '{16, 8, 8, 16};
    localparam int MN [4] = '{1, 1, 1, 3};
    localparam int MR [4] = '{4, 4, 4, 2};
    localparam int MM [4] = '{1, 1, 1, 2};

    int          mcnt [4];
    logic [31:0] mdly [4][3][2];
    logic [31:0] q0[$], q1[$], q2[$], q3[$];
    int          b_seen = 0;
    int          ena_cnt = 0;
    bit          c_fix = 1'b0;
    logic [15:0] c_val = '0;

    function automatic logic [31:0] reduce(input int id, input logic [31:0] y);
        int          w;
        int          ow;
        logic [31:0] mask;
        logic [31:0] s;
        w    = MW[id];
        ow   = MO[id];
        mask = (32'd1 << w) - 1;
        if (w == ow) return y;
`ifdef CIC_COMB_ROUND_EN
        s = (y + (32'd1 << (w - ow - 1))) & mask;
        if (y[w-1] == 1'b0 && s[w-1] == 1'b1) return (32'd1 << (ow - 1)) - 1;
        return s >> (w - ow);
`else
        s = y & mask;
        return s >> (w - ow);
`endif
    endfunction

    task automatic model_capture(input int id, input logic [31:0] din);
        logic [31:0] mask, x, y, r;
        mask = (32'd1 << MW[id]) - 1;
        if (mcnt[id] != MR[id] - 1) begin
            mcnt[id]++;
        end else begin
            mcnt[id] = 0;
            x = din & mask;
            for (int k = 0; k < MN[id]; k++) begin
                y = (x - mdly[id][k][MM[id]-1]) & mask;
                mdly[id][k][1] = mdly[id][k][0];
                mdly[id][k][0] = x;
                x = y;
            end
            r = reduce(id, x);
            case (id)
                0: q0.push_back(r);
                1: q1.push_back(r);
                2: q2.push_back(r);
                default: q3.push_back(r);
            endcase
        end
    endtask

    task automatic model_flush();
        for (int i = 0; i < 4; i++) begin
            mcnt[i] = 0;
            for (int k = 0; k < 3; k++) begin
                mdly[i][k][0] = '0;
                mdly[i][k][1] = '0;
            end
        end
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        b_seen = 0;
        ena_cnt = 0;
    endtask

    task automatic mon_pop(input int id, input logic [31:0] act);
        int          n;
        logic [31:0] e;
        case (id)
            0: n = q0.size();
            1: n = q1.size();
            2: n = q2.size();
            default: n = q3.size();
        endcase
        if (n == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out%0d: got 0x%0h, expected no output", id, act);
        end else begin
            case (id)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                2: e = q2.pop_front();
                default: e = q3.pop_front();
            endcase
            check($sformatf("sb_out%0d", id), act, e);
            if (id == 1) begin
                if (b_seen > 0) check("wrap_steady", act, 32'd40);
                b_seen++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (v_a && rdy_a) mon_pop(0, {16'h0, o_a});
            if (v_b && rdy_o) mon_pop(1, {24'h0, o_b});
            if (v_c && rdy_o) mon_pop(2, {24'h0, o_c});
            if (v_d && rdy_o) mon_pop(3, {16'h0, o_d});
        end
    end

    // Inputs change 1 ns after the rising edge; returns 1 ns after the next one.
    task automatic cycle(input bit e);
        ena = e;
        if (e) begin
            d_a = 16'(ena_cnt);
            d_b = 8'(ena_cnt * 10);
            d_c = c_fix ? c_val : 16'($urandom);
            d_d = 16'($urandom);
            model_capture(0, {16'h0, d_a});
            model_capture(1, {24'h0, d_b});
            model_capture(2, {16'h0, d_c});
            model_capture(3, {16'h0, d_d});
            ena_cnt++;
        end
        @(posedge clk);
        #1;
        ena = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ena = 1'b0;
        #1;
        check("rst_valid_a", {31'h0, v_a}, 32'd0);
        check("rst_overrun_a", {31'h0, ov_a}, 32'd0);
        check("rst_data_a", {16'h0, o_a}, 32'd0);
        check("rst_valid_d", {31'h0, v_d}, 32'd0);
        check("rst_data_c", {24'h0, o_c}, 32'd0);
        model_flush();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_ramp(input int n);
        for (int i = 1; i <= n; i++) begin
            cycle(1'b1);
            check($sformatf("ramp_valid_%0d", i), {31'h0, v_a}, {31'h0, (i >= 6 && i % 4 == 2)});
            if (i == 6)  check("ramp_first", {16'h0, o_a}, 32'd3);
            if (i == 10) check("ramp_second", {16'h0, o_a}, 32'd4);
        end
        repeat (6) cycle(1'b0);
    endtask

    typedef struct {
        logic [15:0] y;
        logic [7:0]  exp_out;
    } vec_t;
    vec_t tbl [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rises[$];
        int cyc;
        bit got;
        logic [15:0] c_acc;

`ifdef CIC_COMB_ROUND_EN
        tbl[0] = '{16'h0180, 8'h02};
        tbl[1] = '{16'h7FFF, 8'h7F};
        tbl[2] = '{16'h0080, 8'h01};
        tbl[3] = '{16'hFF7F, 8'hFF};
        tbl[4] = '{16'h807F, 8'h80};
        tbl[5] = '{16'h7F80, 8'h7F};
`else
        tbl[0] = '{16'h0180, 8'h01};
        tbl[1] = '{16'h7FFF, 8'h7F};
        tbl[2] = '{16'h0080, 8'h00};
        tbl[3] = '{16'hFF7F, 8'hFF};
        tbl[4] = '{16'h807F, 8'h80};
        tbl[5] = '{16'h7F80, 8'h7F};
`endif

        #2;
        do_reset();

        // Ramp with ena every clock; instance b wraps 250 -> 4 along the way.
        run_ramp(40);

        // Ramp with ena one clock in three: outputs 12 clocks apart.
        do_reset();
        cyc = 0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 3; j++) begin
                cycle(j == 0);
                cyc++;
                if (v_a) rises.push_back(cyc);
            end
        end
        check("gap_count", rises.size(), 32'd4);
        if (rises.size() == 4) begin
            check("gap_first", rises[0], 32'd12);
            for (int i = 1; i < 4; i++) check($sformatf("gap_space_%0d", i), rises[i] - rises[i-1], 32'd12);
        end
        repeat (4) cycle(1'b0);

        // Backpressure across two loads.
        do_reset();
        rdy_a = 1'b0;
        repeat (8) cycle(1'b1);
        repeat (2) cycle(1'b0);
        check("bp_valid", {31'h0, v_a}, 32'd1);
        check("bp_data", {16'h0, o_a}, 32'd4);
        check("bp_overrun", {31'h0, ov_a}, 32'd1);
        check("bp_qdepth", q0.size(), 32'd2);
        if (q0.size() > 0) void'(q0.pop_front());
        repeat (2) cycle(1'b0);
        check("bp_stable", {16'h0, o_a}, 32'd4);
        check("bp_sticky", {31'h0, ov_a}, 32'd1);
        rdy_a = 1'b1;
        cycle(1'b0);
        rdy_a = 1'b0;
        check("bp_drained", {31'h0, v_a}, 32'd0);
        cycle(1'b0);
        check("bp_sticky2", {31'h0, ov_a}, 32'd1);
        rdy_a = 1'b1;

        // Load and transfer on the same edge.
        do_reset();
        rdy_a = 1'b0;
        repeat (8) cycle(1'b1);
        cycle(1'b0);
        rdy_a = 1'b1;
        cycle(1'b0);
        check("sim_valid", {31'h0, v_a}, 32'd1);
        check("sim_data", {16'h0, o_a}, 32'd4);
        check("sim_overrun", {31'h0, ov_a}, 32'd0);
        cycle(1'b0);
        check("sim_drained", {31'h0, v_a}, 32'd0);
        repeat (3) cycle(1'b0);

        // Reset between capture and output, then the ramp restarts exactly.
        do_reset();
        rdy_a = 1'b0;
        repeat (8) cycle(1'b1);
        check("midrst_pre_valid", {31'h0, v_a}, 32'd1);
        do_reset();
        rdy_a = 1'b1;
        run_ramp(12);

        // Output reduction table on instance c.
        do_reset();
        c_fix = 1'b1;
        c_acc = '0;
        for (int i = 0; i < 6; i++) begin
            c_acc = c_acc + tbl[i].y;
            c_val = c_acc;
            repeat (4) cycle(1'b1);
            got = 1'b0;
            for (int t = 0; t < 8 && !got; t++) begin
                cycle(1'b0);
                if (v_c) begin
                    check($sformatf("tbl_out_%0d", i), {24'h0, o_c}, {24'h0, tbl[i].exp_out});
                    got = 1'b1;
                end
            end
            if (!got) begin
                total++;
                bad++;
                $display("FAIL tbl_timeout_%0d: got no out_valid, expected one within 8 clocks", i);
            end
        end
        c_fix = 1'b0;

        repeat (8) cycle(1'b0);
        check("q_empty_a", q0.size(), 32'd0);
        check("q_empty_b", q1.size(), 32'd0);
        check("q_empty_c", q2.size(), 32'd0);
        check("q_empty_d", q3.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
